// File: rtl/pma_tx_pkg.sv
// Shared definitions for the PMA transmit serializer family.
package pma_tx_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 10;
  localparam bit          DEF_LSB_FIRST  = 1'b1;
  localparam bit          DEF_IDLE_LEVEL = 1'b0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_bit_select.sv
// Picks one bit of a word by transmit index, honouring the bit order.
module tx_bit_select #(
  parameter int unsigned WIDTH     = 10,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IDX_W-1:0] index,
  output logic             sel_bit
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] pos;

  // Map transmit index to bit position: direct for LSB-first, mirrored otherwise.
  always_comb begin
    pos     = LSB_FIRST ? index : (TOP - index);
    sel_bit = word[pos];
  end

endmodule

// File: rtl/tx_serializer_param.sv
// Parallel-to-serial transmitter with a one-word holding register so that
// consecutive words stream without idle gaps.
module tx_serializer_param
  import pma_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit          LSB_FIRST  = DEF_LSB_FIRST,
  parameter bit          IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Tx_Data_Enable,
  output logic                  Tx_Ready,
  output logic                  TX_Out,
  output logic                  TX_Done,
  output logic                  TX_Busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shifter, shifter_n;
  logic [DATA_WIDTH-1:0] holding, holding_n;
  logic                  hold_valid, hold_valid_n;
  logic                  tx_out_q;
  logic                  accept;
  logic                  last_bit;
  logic                  next_bit;

  assign accept   = Tx_Data_Enable & ~hold_valid;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  assign Tx_Ready = ~hold_valid;
  assign TX_Busy  = (state == SHIFT);
  assign TX_Done  = last_bit;
  assign TX_Out   = tx_out_q;

  // The output bit is chosen from the next-state word/index so TX_Out is
  // registered yet shows the first bit in the cycle right after acceptance.
  tx_bit_select #(
    .WIDTH     (DATA_WIDTH),
    .LSB_FIRST (LSB_FIRST),
    .IDX_W     (CNT_W)
  ) u_bit_select (
    .word    (shifter_n),
    .index   (cnt_n),
    .sel_bit (next_bit)
  );

  // Next-state logic: load, hold, drain-from-hold, bypass and return to idle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shifter_n    = shifter;
    holding_n    = holding;
    hold_valid_n = hold_valid;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shifter_n = Data_in;
          cnt_n     = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_n = cnt + 1'b1;
          if (accept) begin
            holding_n    = Data_in;
            hold_valid_n = 1'b1;
          end
        end else if (hold_valid) begin
          shifter_n    = holding;
          holding_n    = '0;
          hold_valid_n = 1'b0;
          cnt_n        = '0;
        end else if (accept) begin
          shifter_n = Data_in;
          cnt_n     = '0;
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any word in flight.
  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shifter    <= '0;
      holding    <= '0;
      hold_valid <= 1'b0;
      tx_out_q   <= IDLE_LEVEL;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shifter    <= shifter_n;
      holding    <= holding_n;
      hold_valid <= hold_valid_n;
      tx_out_q   <= (state_n == SHIFT) ? next_bit : IDLE_LEVEL;
    end
  end

endmodule

// File: tb/tb_tx_serializer_param.sv
// Directed bench for tx_serializer_param: default 10-bit LSB-first instance
// plus an 8-bit MSB-first instance.
module tb_tx_serializer_param;

  logic       clk;
  logic       rst;
  logic [9:0] d_data;
  logic       d_en;
  logic       d_ready, d_out, d_done, d_busy;
  logic [7:0] m_data;
  logic       m_en;
  logic       m_ready, m_out, m_done, m_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  tx_serializer_param dut (
    .Bit_Rate_Clk   (clk),
    .Rst            (rst),
    .Data_in        (d_data),
    .Tx_Data_Enable (d_en),
    .Tx_Ready       (d_ready),
    .TX_Out         (d_out),
    .TX_Done        (d_done),
    .TX_Busy        (d_busy)
  );

  tx_serializer_param #(
    .DATA_WIDTH (8),
    .LSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) dut_msb (
    .Bit_Rate_Clk   (clk),
    .Rst            (rst),
    .Data_in        (m_data),
    .Tx_Data_Enable (m_en),
    .Tx_Ready       (m_ready),
    .TX_Out         (m_out),
    .TX_Done        (m_done),
    .TX_Busy        (m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0]  w;
    logic [19:0] stream;
    logic [7:0]  exp_msb;

    // Reset with a word offered during the reset cycle.
    rst = 1'b1; d_en = 1'b1; d_data = 10'h3FF; m_en = 1'b1; m_data = 8'hFF;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_out",   16'(d_out),   16'(1'b0));
    chk("rst_ready", 16'(d_ready), 16'(1'b1));
    chk("rst_busy",  16'(d_busy),  16'(1'b0));
    chk("rst_done",  16'(d_done),  16'(1'b0));
    chk("rst_m_busy", 16'(m_busy), 16'(1'b0));
    rst = 1'b0; d_en = 1'b0; m_en = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 16'(d_busy), 16'(1'b0));
    chk("post_rst_out",  16'(d_out),  16'(1'b0));

    // Single word 2AA, Data_in changed while in flight.
    d_data = 10'h2AA; d_en = 1'b1;
    @(posedge clk); #1 d_en = 1'b0; d_data = 10'h0F0;
    w = 10'h2AA;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("single_bit_c%0d", k),  16'(d_out),  16'(w[k-1]));
      chk($sformatf("single_done_c%0d", k), 16'(d_done), 16'(k == 10));
      chk($sformatf("single_busy_c%0d", k), 16'(d_busy), 16'(1'b1));
    end
    @(negedge clk);
    chk("single_idle_out",  16'(d_out),  16'(1'b0));
    chk("single_idle_busy", 16'(d_busy), 16'(1'b0));
    chk("single_idle_done", 16'(d_done), 16'(1'b0));

    // Back-to-back: 3FF then 000 into the holding register.
    @(negedge clk);
    d_data = 10'h3FF; d_en = 1'b1;
    @(posedge clk); #1 d_data = 10'h000; d_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_bit_c%0d", k),  16'(d_out),  16'(k <= 10));
      chk($sformatf("b2b_done_c%0d", k), 16'(d_done), 16'(k == 10 || k == 20));
      chk($sformatf("b2b_busy_c%0d", k), 16'(d_busy), 16'(1'b1));
      if (k == 1) begin
        chk("b2b_ready_c1", 16'(d_ready), 16'(1'b1));
        @(posedge clk); #1 d_en = 1'b0; d_data = 10'h3A5;
      end
      if (k == 2) chk("b2b_ready_c2", 16'(d_ready), 16'(1'b0));
      if (k == 11) chk("b2b_ready_c11", 16'(d_ready), 16'(1'b1));
    end
    @(negedge clk);
    chk("b2b_idle_out",  16'(d_out),  16'(1'b0));
    chk("b2b_idle_busy", 16'(d_busy), 16'(1'b0));

    // Bypass: 155 offered exactly in the TX_Done cycle of 2AA.
    @(negedge clk);
    d_data = 10'h2AA; d_en = 1'b1;
    @(posedge clk); #1 d_en = 1'b0; d_data = 10'h000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("byp_done_c10",  16'(d_done),  16'(1'b1));
        chk("byp_ready_c10", 16'(d_ready), 16'(1'b1));
        d_data = 10'h155; d_en = 1'b1;
      end
    end
    @(posedge clk); #1 d_en = 1'b0; d_data = 10'h3FF;
    w = 10'h155;
    for (int k = 11; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("byp_bit_c%0d", k),  16'(d_out),  16'(w[k-11]));
      chk($sformatf("byp_done_c%0d", k), 16'(d_done), 16'(k == 20));
      chk($sformatf("byp_busy_c%0d", k), 16'(d_busy), 16'(1'b1));
    end
    @(negedge clk);
    chk("byp_idle_busy", 16'(d_busy), 16'(1'b0));

    // Backpressure: A then B held, C offered while hold is full.
    @(negedge clk);
    stream = {10'h2C5, 10'h0F3};
    d_data = 10'h0F3; d_en = 1'b1;
    @(posedge clk); #1 d_data = 10'h2C5; d_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("bp_bit_c%0d", k),  16'(d_out),  16'(stream[k-1]));
      chk($sformatf("bp_done_c%0d", k), 16'(d_done), 16'(k == 10 || k == 20));
      if (k == 1) begin
        @(posedge clk); #1 d_data = 10'h3FF; d_en = 1'b1;
      end
      if (k == 2 || k == 5) chk($sformatf("bp_ready_c%0d", k), 16'(d_ready), 16'(1'b0));
      if (k == 9) d_en = 1'b0;
    end
    @(negedge clk);
    chk("bp_idle_out",  16'(d_out),  16'(1'b0));
    chk("bp_idle_busy", 16'(d_busy), 16'(1'b0));

    // Reset mid-word with a second word held.
    @(negedge clk);
    d_data = 10'h3FF; d_en = 1'b1;
    @(posedge clk); #1 d_data = 10'h155; d_en = 1'b1;
    @(posedge clk); #1 d_en = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("rmid_bit_c%0d", k), 16'(d_out), 16'(1'b1));
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 6; k <= 22; k++) begin
      @(negedge clk);
      chk($sformatf("rmid_out_c%0d", k),  16'(d_out),  16'(1'b0));
      chk($sformatf("rmid_done_c%0d", k), 16'(d_done), 16'(1'b0));
      chk($sformatf("rmid_busy_c%0d", k), 16'(d_busy), 16'(1'b0));
      chk($sformatf("rmid_rdy_c%0d", k),  16'(d_ready), 16'(1'b1));
    end

    // MSB-first, 8-bit: C1 transmits as 1,1,0,0,0,0,0,1 (first bit leftmost).
    exp_msb = 8'b1100_0001;
    @(negedge clk);
    m_data = 8'hC1; m_en = 1'b1;
    @(posedge clk); #1 m_en = 1'b0; m_data = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("msb_bit_c%0d", k),  16'(m_out),  16'(exp_msb[8-k]));
      chk($sformatf("msb_done_c%0d", k), 16'(m_done), 16'(k == 8));
    end
    @(negedge clk);
    chk("msb_idle_busy", 16'(m_busy), 16'(1'b0));
    chk("msb_idle_done", 16'(m_done), 16'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_serializer_param.md
TX_SERIALIZER_PARAM -- requirements
Module: tx_serializer_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 10, giving the parallel word width (legal range 2..64).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 transmitted first, 0 = bit DATA_WIDTH-1 first.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 0, giving the TX_Out level when no word is being sent.
REQ-004 Port Bit_Rate_Clk  input  1  serial bit-rate clock; one bit per rising edge.
REQ-005 Port Rst  input  1  reset; one clock, synchronous and active-high.
REQ-006 Port Data_in  input  DATA_WIDTH  parallel word to transmit.
REQ-007 Port Tx_Data_Enable  input  1  word valid; a word is accepted when Tx_Data_Enable and Tx_Ready are both high on a rising edge.
REQ-008 Port Tx_Ready  output  1  holding register empty; a word can be accepted.
REQ-009 Port TX_Out  output  1  registered serial data.
REQ-010 Port TX_Done  output  1  one-cycle pulse, high while the last bit of a word is on TX_Out.
REQ-011 Port TX_Busy  output  1  high while a word is being shifted out.

Function
REQ-012 The block SHALL contain a DATA_WIDTH-bit shift register, a DATA_WIDTH-bit holding register with valid flag, and a bit counter of width $clog2(DATA_WIDTH).
REQ-013 The FSM SHALL have states IDLE and SHIFT.
REQ-014 Tx_Ready SHALL equal NOT hold_valid and SHALL NOT depend combinationally on Tx_Data_Enable.
REQ-015 In IDLE, a word accepted at edge N SHALL load directly into the shifter, giving TX_Out = first bit in cycle N+1 and entry to SHIFT.
REQ-016 In SHIFT, bits SHALL appear on consecutive cycles N+1..N+DATA_WIDTH, with the counter running 0..DATA_WIDTH-1.
REQ-017 TX_Done SHALL be high exactly in the cycle where the counter equals DATA_WIDTH-1.
REQ-018 In SHIFT with the counter below DATA_WIDTH-1, an accepted word SHALL go to the holding register and set hold_valid.
REQ-019 In the TX_Done cycle, if hold_valid is set, the next cycle SHALL output the held word's first bit and clear hold_valid, with no gap.
REQ-020 In the TX_Done cycle, if hold_valid is clear and a word is accepted that same cycle, the word SHALL bypass the holding register into the shifter, with no gap.
REQ-021 In the TX_Done cycle, if no word is held or accepted, the FSM SHALL return to IDLE and the next cycle SHALL have TX_Out = IDLE_LEVEL and TX_Busy = 0.
REQ-022 In IDLE, TX_Out SHALL equal IDLE_LEVEL.
REQ-023 TX_Busy SHALL equal (state == SHIFT).
REQ-024 Data_in SHALL be sampled only on an accepted edge; later changes SHALL NOT affect a word in flight.
REQ-025 When hold_valid is set, Tx_Data_Enable SHALL be ignored and no word SHALL be lost or overwritten.

Reset
REQ-026 While Rst is high at an edge, the block SHALL set state = IDLE, counter = 0, shifter = 0, holding = 0, hold_valid = 0, TX_Out = IDLE_LEVEL, TX_Done = 0, TX_Busy = 0 and Tx_Ready = 1.
REQ-027 Rst asserted mid-word SHALL abort the word and discard any held word, with no TX_Done pulse generated.
REQ-028 A word presented with Tx_Data_Enable during the reset cycle SHALL NOT be accepted.

Structure
REQ-029 The FSM state enum and the default DATA_WIDTH, LSB_FIRST and IDLE_LEVEL values SHALL live in shared package pma_tx_pkg.
REQ-030 The bit-order selection SHALL be a sub-module tx_bit_select (word, index, LSB_FIRST -> bit); all other logic SHALL be flat.

Verification (DATA_WIDTH=10 unless stated)
REQ-031 Single word: Data_in=10'h2AA accepted at edge 0 -> TX_Out = 0,1,0,1,0,1,0,1,0,1 in cycles 1..10, TX_Done only in cycle 10, IDLE_LEVEL in cycle 11.
REQ-032 Back-to-back: 10'h3FF at edge 0, then 10'h000 while Tx_Ready=1 -> ten 1s then ten 0s in cycles 1..20, TX_Done in cycles 10 and 20, TX_Busy continuously high.
REQ-033 Bypass: with hold empty, 10'h155 accepted exactly in a TX_Done cycle -> its first bit (1) appears the next cycle, with no idle gap.
REQ-034 Backpressure: third word offered while hold_valid=1 -> Tx_Ready=0, word not accepted, and the first two words are transmitted intact.
REQ-035 Reset mid-word: Rst high in cycle 5 of 10'h3FF -> TX_Out=IDLE_LEVEL and Tx_Ready=1 from cycle 6, with no TX_Done pulse.
REQ-036 MSB mode: LSB_FIRST=0, DATA_WIDTH=8, Data_in=8'hC1 -> TX_Out = 1,1,0,0,0,0,0,1 and TX_Done in cycle 8.
